// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan-bus receiver: segment patterns,
// FSM states and small helpers used by the top and the pattern decoder.
package seg_scan_capture_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low, common-anode patterns; bit7 is the decimal point (off).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_CONV,
        ST_DONE
    } state_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            n = n + int'(v[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/seg_scan_capture_decode.sv
// Combinational 7-segment pattern to decimal digit decoder.
// Anything other than the ten exact digit patterns is reported invalid.
module seg7_pattern_decode
    import seg_scan_capture_pkg::*;
(
    input  logic [7:0] pattern,
    output logic       valid,
    output logic [3:0] digit
);

    always_comb begin
        valid = 1'b1;
        digit = 4'd0;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Receives a 6-digit multiplexed 7-segment scan, debounces each digit, assembles a frame
// and converts it to binary; data_valid follows the sixth accepted digit by 8 cycles.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  sel_in,
    input  logic [7:0]  sec_in,
    output logic [23:0] data_out,
    output logic [23:0] bcd_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        link_lost
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

    logic [5:0]        sel_q, sel_p;
    logic [7:0]        sec_q, sec_p;
    logic [SW-1:0]     stab_cnt, stab_nxt;
    logic [TW-1:0]     tmo_cnt;
    logic              same, accept, tmo_hit;
    logic              dec_vld;
    logic [3:0]        dec_dig;
    logic [5:0][3:0]   nib;
    logic [5:0]        err, mask, mask_nxt;
    logic [23:0]       acc;
    logic [2:0]        conv_idx;
    logic [3:0]        nib_sel;
    state_t            state;

    seg7_pattern_decode u_dec (
        .pattern (sec_q),
        .valid   (dec_vld),
        .digit   (dec_dig)
    );

    // Accept fires only on the sample where the count first reaches SETTLE_CYC,
    // so a long dwell produces one accept rather than one per cycle.
    always_comb begin
        same     = (sel_q == sel_p) && (sec_q == sec_p);
        stab_nxt = SW'(1);
        if (same) begin
            stab_nxt = (stab_cnt == SETTLE_MAX) ? stab_cnt : stab_cnt + 1'b1;
        end
        accept   = is_onehot(sel_q) && (stab_nxt == SETTLE_MAX) &&
                   !(same && (stab_cnt == SETTLE_MAX));
        tmo_hit  = !accept && (tmo_cnt == TMO_LAST);
        mask_nxt = mask | sel_q;
        nib_sel  = nib[3'd5 - conv_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= '0;
            sec_q    <= SEG_BLANK;
            sel_p    <= '0;
            sec_p    <= SEG_BLANK;
            stab_cnt <= '0;
        end else begin
            sel_q    <= sel_in;
            sec_q    <= sec_in;
            sel_p    <= sel_q;
            sec_p    <= sec_q;
            stab_cnt <= stab_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt    <= '0;
            link_lost  <= 1'b1;
            nib        <= '0;
            err        <= '0;
            mask       <= '0;
            acc        <= '0;
            conv_idx   <= '0;
            state      <= ST_COLLECT;
            data_out   <= '0;
            bcd_out    <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (accept) begin
                tmo_cnt   <= '0;
                link_lost <= 1'b0;
            end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_hit) begin
                    link_lost <= 1'b1;
                end
            end

            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (sel_q[i]) begin
                                nib[i] <= dec_dig;
                                err[i] <= !dec_vld;
                            end
                        end
                        mask <= mask_nxt;
                        if (mask_nxt == 6'h3F) begin
                            state    <= ST_CONV;
                            acc      <= '0;
                            conv_idx <= '0;
                        end
                    end else if (tmo_hit) begin
                        mask <= '0;
                        err  <= '0;
                    end
                end
                ST_CONV: begin
                    // Most significant digit first: acc*10 + digit.
                    acc      <= (acc << 3) + (acc << 1) + {20'd0, nib_sel};
                    conv_idx <= conv_idx + 3'd1;
                    if (conv_idx == 3'd5) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (|err) begin
                        frame_err <= 1'b1;
                    end else begin
                        data_out   <= acc;
                        bcd_out    <= nib;
                        data_valid <= 1'b1;
                    end
                    mask  <= '0;
                    err   <= '0;
                    state <= ST_COLLECT;
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized scan-bus bench: frames are scored against a digit-list model of the display.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  sel_in;
    logic [7:0]  sec_in;
    logic [23:0] data_out;
    logic [23:0] bcd_out;
    logic        data_valid;
    logic        frame_err;
    logic        link_lost;

    seg_scan_capture #(.SETTLE_CYC(4), .TIMEOUT_CYC(200)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_in     (sel_in),
        .sec_in     (sec_in),
        .data_out   (data_out),
        .bcd_out    (bcd_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .link_lost  (link_lost)
    );

    always #5 clk = ~clk;

    logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] bad_pats [4] = '{8'hFF, 8'h00, 8'h7F, 8'hC1};

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_cyc;
    bit both_seen = 0;
    int ev_kind [$];
    int ev_cyc [$];

    int         cur_dig [6];
    bit         cur_bad [6];
    logic [7:0] cur_badpat;
    int         exp_val = 0;
    int         exp_bcd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                ev_kind.push_back(1);
                ev_cyc.push_back(cyc);
            end
            if (frame_err) begin
                ev_kind.push_back(2);
                ev_cyc.push_back(cyc);
            end
            if (data_valid && frame_err) both_seen = 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic put(input logic [5:0] s, input logic [7:0] g, input int n);
        sel_in = s;
        sec_in = g;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_val(input int v);
        int r;
        r = v;
        for (int i = 0; i < 6; i++) begin
            cur_dig[i] = r % 10;
            cur_bad[i] = 0;
            r = r / 10;
        end
    endtask

    task automatic scan_range(input int first, input int last, input int dwell,
                              input bit glitch, input bit gaps);
        logic [7:0] seg;
        logic [5:0] s;
        int p;
        for (int i = first; i <= last; i++) begin
            seg = cur_bad[i] ? cur_badpat : pat[cur_dig[i]];
            s   = 6'(1 << i);
            if (i == last) last_cyc = cyc;
            if (glitch && i != last && $urandom_range(0, 1) == 1) begin
                p = $urandom_range(1, dwell - 2);
                put(s, seg, p);
                put(s, 8'h80, 1);
                put(s, seg, dwell - p - 1);
            end else begin
                put(s, seg, dwell);
            end
            if (gaps && i != last) begin
                case ($urandom_range(0, 2))
                    0: put(6'b000000, pat[8], $urandom_range(0, 6));
                    1: put(6'b100001, pat[8], $urandom_range(0, 6));
                    default: put(6'b011000, pat[3], $urandom_range(0, 6));
                endcase
            end
        end
    endtask

    // Reference: a good frame shows sum(digit_i * 10^i); any bad digit gives an error and
    // leaves the previous value. Result appears 4 settle samples + 8 cycles after last drive.
    task automatic expect_frame(input string tag);
        bit any_bad;
        int v, pw, b;
        any_bad = 0;
        v = 0;
        pw = 1;
        b = 0;
        for (int i = 0; i < 6; i++) begin
            any_bad = any_bad | cur_bad[i];
            v  = v + cur_dig[i] * pw;
            pw = pw * 10;
            b  = b | (cur_dig[i] << (4 * i));
        end
        if (!any_bad) begin
            exp_val = v;
            exp_bcd = b;
        end
        check({tag, "_events"}, 32'(ev_kind.size()), 32'd1);
        if (ev_kind.size() >= 1) begin
            check({tag, "_kind"}, 32'(ev_kind[0]), any_bad ? 32'd2 : 32'd1);
            check({tag, "_latency"}, 32'(ev_cyc[0] - last_cyc), 32'd12);
        end
        check({tag, "_data"}, 32'(data_out), 32'(exp_val));
        check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        ev_kind.delete();
        ev_cyc.delete();
    endtask

    task automatic run_frame(input string tag, input int dwell, input bit glitch, input bit gaps);
        ev_kind.delete();
        ev_cyc.delete();
        scan_range(0, 5, dwell, glitch, gaps);
        put(6'b000000, 8'hFF, 15);
        expect_frame(tag);
    endtask

    initial begin
        rst    = 1'b1;
        sel_in = '0;
        sec_in = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_link", 32'(link_lost), 32'd1);
        rst = 1'b0;
        put(6'b000000, 8'hFF, 5);

        set_val(123456);
        run_frame("f123456", 50, 0, 0);
        check("link_up", 32'(link_lost), 32'd0);
        set_val(999999);
        run_frame("f999999", 50, 0, 0);
        set_val(0);
        run_frame("f000000", 50, 0, 0);
        set_val(123456);
        run_frame("f123456b", 40, 0, 0);

        set_val(654321);
        cur_bad[1] = 1;
        cur_badpat = 8'hFF;
        run_frame("tens_blank", 40, 0, 0);

        set_val(111111);
        run_frame("glitch", 40, 1, 0);

        for (int f = 0; f < 12; f++) begin
            set_val(int'($urandom_range(0, 999999)));
            if ($urandom_range(0, 3) == 0) begin
                cur_bad[$urandom_range(0, 5)] = 1;
                cur_badpat = bad_pats[$urandom_range(0, 3)];
            end
            run_frame($sformatf("rand%0d", f), int'($urandom_range(20, 60)), 1, 1);
        end

        // Partial frame then silence: link drops and the partial digits are discarded.
        ev_kind.delete();
        ev_cyc.delete();
        set_val(314159);
        scan_range(0, 2, 50, 0, 0);
        put(6'b000000, 8'hFF, 100);
        check("tmo_before", 32'(link_lost), 32'd0);
        put(6'b000000, 8'hFF, 100);
        check("tmo_after", 32'(link_lost), 32'd1);
        set_val(271828);
        scan_range(3, 5, 50, 0, 0);
        put(6'b000000, 8'hFF, 20);
        check("tmo_partial_events", 32'(ev_kind.size()), 32'd0);
        check("tmo_relink", 32'(link_lost), 32'd0);
        scan_range(0, 2, 50, 0, 0);
        put(6'b000000, 8'hFF, 15);
        expect_frame("tmo_restart");

        // Reset while the conversion is running.
        ev_kind.delete();
        ev_cyc.delete();
        set_val(555444);
        scan_range(0, 4, 40, 0, 0);
        put(6'b100000, pat[cur_dig[5]], 8);
        rst = 1'b1;
        put(6'b000000, 8'hFF, 1);
        check("rstconv_data", 32'(data_out), 32'd0);
        check("rstconv_bcd", 32'(bcd_out), 32'd0);
        check("rstconv_valid", 32'(data_valid), 32'd0);
        check("rstconv_err", 32'(frame_err), 32'd0);
        check("rstconv_link", 32'(link_lost), 32'd1);
        rst = 1'b0;
        put(6'b000000, 8'hFF, 30);
        check("rstconv_events", 32'(ev_kind.size()), 32'd0);
        exp_val = 0;
        exp_bcd = 0;
        set_val(802017);
        run_frame("after_rst", 30, 0, 0);

        check("valid_err_exclusive", 32'(both_seen), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
